eth_rx_dispatch: RTL
====================

# eth_rx_dispatch

Frame-level controller for the Ethernet receive path. It starts the MAC receiver on each detected frame and waits for the receiver to reach payload. It then classifies the frame by EtherType and destination MAC, and hands the payload window to one of two protocol handlers (ARP, IPv4) through fs/fd handshakes. It closes the receiver handshake once the chosen handler finishes, the frame is dropped, or a handler timeout expires.

## Interface
Parameters:
- LOCAL_MAC, 48'h000A35000001, station address accepted by the filter
- TIMEOUT, 16'd2048, maximum cycles a handler may hold a frame; legal range 2..65535

Ports (reset rst, asynchronous, active-high; clock clk):
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- frame_start  in  1  frame detected upstream; level, held for the frame duration
- mac_fs  out  1  frame start to MAC receiver
- mac_fd  in  1  frame done from MAC receiver
- mode_fs  in  1  payload window open, from MAC receiver
- mode_fd  out  1  payload consumed, to MAC receiver
- eth_type  in  16  EtherType from MAC receiver; stable while mode_fs=1
- dst_mac  in  48  destination MAC from MAC receiver; stable while mode_fs=1
- arp_fs  out  1  ARP handler start
- arp_fd  in  1  ARP handler done
- ip_fs  out  1  IPv4 handler start
- ip_fd  in  1  IPv4 handler done
- drop_cnt  out  16  dropped plus timed-out frames; saturates at 16'hFFFF
- busy  out  1  high in every state except IDLE and WAIT

## Operation
States and transitions:
- IDLE: go to WAIT unconditionally.
- WAIT: frame_start=1 -> HOLD.
- HOLD: mode_fs=1 -> CHECK.
- CHECK: evaluate in a single cycle.
  - Filter fails -> DROP.
  - eth_type==16'h0806 -> ARP.
  - eth_type==16'h0800 -> IP.
  - Any other EtherType -> DROP.
- ARP: arp_fd=1 -> REST. If arp_fd=0 and cnt==TIMEOUT-1 -> REST, with drop_cnt incremented.
- IP: same as ARP, using ip_fd.
- DROP: increment drop_cnt, then go to REST.
- REST: mac_fd=1 -> DONE.
- DONE: frame_start=0 -> WAIT.

Output decode. All handshake outputs are decoded from the registered state, with no extra register stage:
- mac_fs=1 in HOLD, CHECK, ARP, IP, DROP and REST.
- mode_fd=1 in REST.
- arp_fs=1 in ARP only.
- ip_fs=1 in IP only.

Counters and sampled inputs:
- The 16-bit cnt clears on every state change and increments in ARP and IP only.
- Filter passes when dst_mac==LOCAL_MAC or dst_mac==48'hFFFFFFFFFFFF.
- eth_type and dst_mac are sampled only in CHECK.

Boundary rules:
- When the handler fd and the timeout land in the same cycle, fd wins and drop_cnt is not incremented.
- While in ARP, ip_fd is ignored. While in IP, arp_fd is ignored. Any fd arriving after REST is entered is ignored.
- frame_start falling before DONE is ignored; the frame is always completed.
- drop_cnt does not wrap: at 16'hFFFF, further increments are discarded.
- On reset, including mid-frame, every output returns to 0 immediately, state goes to IDLE, and drop_cnt clears.

## Timing
- Reset values: mac_fs=0, mode_fd=0, arp_fs=0, ip_fs=0, drop_cnt=0, busy=0.
- frame_start sampled high in WAIT at cycle n -> mac_fs high from cycle n+1.
- mode_fs sampled high in HOLD at cycle m -> CHECK at m+1, handler fs high from m+2.
- Handler fd sampled at cycle k -> handler fs low and mode_fd high from k+1.
- Timeout: handler fs is high for exactly TIMEOUT cycles, then mode_fd goes high.
- Drop path: CHECK at m+1, DROP at m+2, mode_fd high from m+3. drop_cnt updates at the end of the DROP cycle.
- mac_fd sampled in REST at cycle r -> mac_fs and mode_fd low from r+1.
- Minimum frame-to-frame gap: one WAIT cycle after frame_start falls.

## Configuration
- RX_DISPATCH_FILTER_EN defined: the destination MAC filter is active as described in Operation.
- RX_DISPATCH_FILTER_EN undefined: the filter always passes, so classification uses eth_type only. The dst_mac port remains present but unused.

## Test plan
- ARP broadcast: dst_mac=FF..FF, eth_type=0806, arp_fd pulsed 20 cycles after arp_fs rises -> arp_fs high for 20 cycles, mode_fd high until mac_fd, ip_fs never high, drop_cnt=0.
- IPv4 unicast: dst_mac=LOCAL_MAC, eth_type=0800, ip_fd after 5 cycles -> ip_fs high for 5 cycles, mac_fs falls 1 cycle after mac_fd, busy low after frame_start falls.
- Unknown type: eth_type=86DD -> no handler fs, mode_fd high 2 cycles after CHECK, drop_cnt=1.
- Filter: dst_mac=000A35000002, eth_type=0800.
  - With RX_DISPATCH_FILTER_EN: frame is dropped and drop_cnt increments.
  - Without it: ip_fs asserts.
- Timeout: TIMEOUT=16, ip_fd held low -> ip_fs high for exactly 16 cycles, then REST, drop_cnt +1. A later ip_fd pulse is ignored.
- Reset mid-IP: rst pulsed while ip_fs=1 -> all outputs 0 asynchronously, drop_cnt=0, WAIT one cycle after release, next frame processes normally.

Source files
------------

// File: rtl/eth_rx_dispatch.sv
// eth_rx_dispatch: RX frame controller dispatching payload to ARP/IPv4 handlers; RX_DISPATCH_FILTER_EN enables the dst MAC filter.
module eth_rx_dispatch #(
    parameter logic [47:0] LOCAL_MAC = 48'h000A35000001,
    parameter logic [15:0] TIMEOUT   = 16'd2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    output logic        mac_fs,
    input  logic        mac_fd,
    input  logic        mode_fs,
    output logic        mode_fd,
    input  logic [15:0] eth_type,
    input  logic [47:0] dst_mac,
    output logic        arp_fs,
    input  logic        arp_fd,
    output logic        ip_fs,
    input  logic        ip_fd,
    output logic [15:0] drop_cnt,
    output logic        busy
);
    typedef enum logic [3:0] {IDLE, WAIT, HOLD, CHECK, ARP, IP, DROP, REST, DONE} state_t;
    state_t state_q, state_d;
    logic [15:0] cnt_q, cnt_d, drop_q, drop_d;
    logic filt, hs_fd, tmo, drop_inc;
`ifdef RX_DISPATCH_FILTER_EN
    assign filt = (dst_mac == LOCAL_MAC) || (dst_mac == 48'hFFFFFFFFFFFF);
`else
    logic unused_dst;
    assign unused_dst = ^dst_mac;
    assign filt = 1'b1;
`endif
    always_comb begin
        hs_fd    = (state_q == ARP) ? arp_fd : ip_fd;
        tmo      = cnt_q == TIMEOUT - 16'd1;
        state_d  = state_q;
        drop_inc = 1'b0;
        case (state_q)
            IDLE:    state_d = WAIT;
            WAIT:    state_d = frame_start ? HOLD : WAIT;
            HOLD:    state_d = mode_fs ? CHECK : HOLD;
            CHECK:   state_d = !filt ? DROP : eth_type == 16'h0806 ? ARP : eth_type == 16'h0800 ? IP : DROP;
            ARP, IP: begin
                // fd beats a coincident timeout, so only a bare timeout counts as a drop
                state_d  = (hs_fd || tmo) ? REST : state_q;
                drop_inc = tmo && !hs_fd;
            end
            DROP: begin
                state_d  = REST;
                drop_inc = 1'b1;
            end
            REST:    state_d = mac_fd ? DONE : REST;
            DONE:    state_d = frame_start ? DONE : WAIT;
            default: state_d = IDLE;
        endcase
        cnt_d  = (state_d != state_q) ? 16'd0 : (state_q == ARP || state_q == IP) ? cnt_q + 16'd1 : cnt_q;
        drop_d = (drop_inc && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            drop_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end
    assign mac_fs   = state_q inside {HOLD, CHECK, ARP, IP, DROP, REST};
    assign mode_fd  = state_q == REST;
    assign arp_fs   = state_q == ARP;
    assign ip_fs    = state_q == IP;
    assign busy     = !(state_q == IDLE || state_q == WAIT);
    assign drop_cnt = drop_q;
endmodule
